dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array with true-LRU replacement, per-line valid and dirty bits, and single-line invalidate. It sits between the dcache controller and its backing memory interface and replaces the fixed 2-way array with a configurable way count, set count, tag width and line width. Lookup is combinational. Tag, data, valid, dirty and LRU state update on the clock edge.

---
 rtl/dcache_sram_nway.sv | 107 ++++++++++
 tb/tb_dcache_sram_nway.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative dcache storage with true-LRU, valid/dirty bits and invalidate
//
// Ports:
//   clk_i, rst_n_i          clock and asynchronous active-low reset
//   enable_i                access qualifier; state is frozen when low
//   write_i, inv_i          write/fill (priority) or invalidate of the hit line
//   addr_i, tag_i           set index and lookup/write tag
//   data_i, dirty_i         line and dirty bit stored by a write
//   hit_o, way_o            hit flag; hit way on hit, victim way on miss
//   tag_o, data_o           tag and line of the selected way
//   valid_o, dirty_o        valid and dirty bits of the selected way
module dcache_sram_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              inv_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              valid_o,
    output logic              dirty_o
);
    function automatic logic [WAYS-1:0][WAY_W-1:0] init_age();
        logic [WAYS-1:0][WAY_W-1:0] a;
        for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction

    localparam logic [WAYS-1:0][WAY_W-1:0] AGE0 = init_age();

    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tags;
    logic [SETS-1:0][WAYS-1:0][LINE_W-1:0] lines;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age;
    logic [SETS-1:0][WAYS-1:0]             vld;
    logic [SETS-1:0][WAYS-1:0]             dty;

    logic                        hit;
    logic [WAY_W-1:0]            hway;
    logic [WAY_W-1:0]            vic;
    logic [WAY_W-1:0]            sel;
    logic [WAY_W-1:0]            tgt;
    logic [WAYS-1:0][WAY_W-1:0]  nage;

    // Victim starts as the LRU way; the descending scan then lets the
    // lowest-index invalid way override it.
    always_comb begin
        hit  = 1'b0;
        hway = '0;
        vic  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld[addr_i][w] && tags[addr_i][w] == tag_i) begin
                hit  = 1'b1;
                hway = WAY_W'(w);
            end
            if (age[addr_i][w] == WAY_W'(WAYS - 1)) vic = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!vld[addr_i][w]) vic = WAY_W'(w);
        sel = hit ? hway : vic;
        tgt = write_i ? sel : hway;
        for (int w = 0; w < WAYS; w++)
            nage[w] = (WAY_W'(w) == tgt) ? '0 :
                      (age[addr_i][w] < age[addr_i][tgt]) ? age[addr_i][w] + 1'b1 : age[addr_i][w];
    end

    assign hit_o   = hit;
    assign way_o   = sel;
    assign tag_o   = tags[addr_i][sel];
    assign data_o  = lines[addr_i][sel];
    assign valid_o = vld[addr_i][sel];
    assign dirty_o = dty[addr_i][sel];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tags  <= '0;
            lines <= '0;
            vld   <= '0;
            dty   <= '0;
            age   <= {SETS{AGE0}};
        end else if (enable_i) begin
            if (write_i) begin
                tags[addr_i][sel]  <= tag_i;
                lines[addr_i][sel] <= data_i;
                vld[addr_i][sel]   <= 1'b1;
                dty[addr_i][sel]   <= dirty_i;
            end else if (inv_i && hit) begin
                vld[addr_i][hway] <= 1'b0;
                dty[addr_i][hway] <= 1'b0;
            end
            // Invalidate leaves ages alone; reads touch only on hit.
            if (write_i || (!inv_i && hit)) age[addr_i] <= nage;
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: randomized and directed checks of two dcache_sram_nway configurations against a recency-stamp model
module tb_dcache_sram_nway;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         en[2], wr[2], inv[2], dty[2];
    logic [3:0]   idx[2];
    logic [24:0]  tg[2];
    logic [255:0] dat[2];

    logic         hit0, valid0, dirty0, hit1, valid1, dirty1;
    logic [1:0]   way0;
    logic [0:0]   way1;
    logic [24:0]  tag0, tag1;
    logic [255:0] data0;
    logic [63:0]  data1;

    int errors = 0;
    int checks = 0;

    dcache_sram_nway dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[0]), .write_i(wr[0]), .inv_i(inv[0]),
        .addr_i(idx[0]), .tag_i(tg[0]), .data_i(dat[0]), .dirty_i(dty[0]),
        .hit_o(hit0), .way_o(way0), .tag_o(tag0), .data_o(data0), .valid_o(valid0), .dirty_o(dirty0)
    );

    dcache_sram_nway #(.WAYS(2), .SETS(4), .TAG_W(25), .LINE_W(64)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[1]), .write_i(wr[1]), .inv_i(inv[1]),
        .addr_i(idx[1][1:0]), .tag_i(tg[1]), .data_i(dat[1][63:0]), .dirty_i(dty[1]),
        .hit_o(hit1), .way_o(way1), .tag_o(tag1), .data_o(data1), .valid_o(valid1), .dirty_o(dirty1)
    );

    // Model: each line remembers when it was last touched; LRU is the oldest stamp.
    int           nw[2] = '{4, 2};
    int           ns[2] = '{16, 4};
    logic [24:0]  m_tag[2][16][4];
    logic [255:0] m_data[2][16][4];
    bit           m_valid[2][16][4];
    bit           m_dirty[2][16][4];
    longint       m_stamp[2][16][4];
    longint       now = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 16; s++)
                for (int w = 0; w < 4; w++) begin
                    m_tag[d][s][w] = '0; m_data[d][s][w] = '0;
                    m_valid[d][s][w] = 0; m_dirty[d][s][w] = 0;
                    m_stamp[d][s][w] = -w;
                end
    endtask

    function automatic int victim(int d, int a);
        int best = 0;
        for (int i = 0; i < nw[d]; i++) if (!m_valid[d][a][i]) return i;
        for (int i = 1; i < nw[d]; i++) if (m_stamp[d][a][i] < m_stamp[d][a][best]) best = i;
        return best;
    endfunction

    function automatic logic [285:0] mexp(int d, int a, int t);
        int w = victim(d, a);
        logic h = 1'b0;
        for (int i = 0; i < nw[d]; i++)
            if (m_valid[d][a][i] && m_tag[d][a][i] == 25'(t)) begin h = 1'b1; w = i; end
        return {h, 2'(w), m_tag[d][a][w], m_data[d][a][w], m_valid[d][a][w], m_dirty[d][a][w]};
    endfunction

    function automatic logic [285:0] obs(int d);
        if (d == 0) return {hit0, way0, tag0, data0, valid0, dirty0};
        return {hit1, 1'b0, way1, tag1, 192'b0, data1, valid1, dirty1};
    endfunction

    function automatic logic g_hit(int d);
        logic [285:0] o = obs(d);
        return o[285];
    endfunction

    function automatic int g_way(int d);
        logic [285:0] o = obs(d);
        return int'(o[284:283]);
    endfunction

    function automatic logic [24:0] g_tag(int d);
        logic [285:0] o = obs(d);
        return o[282:258];
    endfunction

    task automatic apply(int d);
        int a, hw, w;
        bit h;
        if (!en[d]) return;
        a = int'(idx[d]) & (ns[d] - 1);
        h = 0; hw = 0;
        for (int i = 0; i < nw[d]; i++)
            if (m_valid[d][a][i] && m_tag[d][a][i] == tg[d]) begin h = 1; hw = i; end
        now++;
        if (wr[d]) begin
            w = h ? hw : victim(d, a);
            m_tag[d][a][w] = tg[d];
            m_data[d][a][w] = d ? {192'b0, dat[d][63:0]} : dat[d];
            m_valid[d][a][w] = 1; m_dirty[d][a][w] = dty[d];
            m_stamp[d][a][w] = now;
        end else if (inv[d]) begin
            if (h) begin m_valid[d][a][hw] = 0; m_dirty[d][a][hw] = 0; end
        end else if (h) m_stamp[d][a][hw] = now;
    endtask

    task automatic drive(int d, bit e, bit w, bit i, int a, int t, logic [255:0] dd, bit dy);
        en[d] = e; wr[d] = w; inv[d] = i; idx[d] = 4'(a); tg[d] = 25'(t); dat[d] = dd; dty[d] = dy;
    endtask

    task automatic tick();
        @(posedge clk);
        apply(0);
        apply(1);
        @(negedge clk);
        en[0] = 0; en[1] = 0;
    endtask

    function automatic logic [255:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            drive(d, 1, 0, 0, 3, 1, '0, 0);
            #1;
            checks++;
            if (obs(d) !== '0) begin
                errors++;
                $display("FAIL reset_read d=%0d got=%h exp=0", d, obs(d));
            end
            checks++;
            if (obs(d) !== mexp(d, 3, 1)) begin
                errors++;
                $display("FAIL reset_model d=%0d got=%h exp=%h", d, obs(d), mexp(d, 3, 1));
            end
        end
        tick();
    endtask

    task automatic test_fill_evict(int d);
        int a = (d == 0) ? 5 : 1;
        int tags[4] = '{'hA, 'hB, 'hC, 'hD};
        for (int i = 0; i < nw[d]; i++) begin
            drive(d, 1, 1, 0, a, tags[i], rnd_line(), 0);
            #1;
            checks++;
            if (g_hit(d) !== 1'b0 || g_way(d) != i) begin
                errors++;
                $display("FAIL fill_way d=%0d i=%0d got hit=%0b way=%0d exp hit=0 way=%0d", d, i, g_hit(d), g_way(d), i);
            end
            tick();
        end
        for (int i = 0; i < nw[d]; i++) begin
            drive(d, 1, 0, 0, a, tags[i], '0, 0);
            #1;
            checks++;
            if (g_hit(d) !== 1'b1 || g_way(d) != i || obs(d) !== mexp(d, a, tags[i])) begin
                errors++;
                $display("FAIL readback d=%0d i=%0d got=%h exp=%h", d, i, obs(d), mexp(d, a, tags[i]));
            end
            tick();
        end
        drive(d, 1, 0, 0, a, 'hA, '0, 0);
        tick();
        drive(d, 1, 0, 0, a, 'hE, '0, 0);
        #1;
        checks++;
        if (g_hit(d) !== 1'b0 || g_way(d) != 1 || g_tag(d) !== 25'hB) begin
            errors++;
            $display("FAIL evict_sel d=%0d got hit=%0b way=%0d tag=%h exp hit=0 way=1 tag=b", d, g_hit(d), g_way(d), g_tag(d));
        end
        checks++;
        if (obs(d) !== mexp(d, a, 'hE)) begin
            errors++;
            $display("FAIL evict_model d=%0d got=%h exp=%h", d, obs(d), mexp(d, a, 'hE));
        end
        drive(d, 1, 1, 0, a, 'hE, rnd_line(), 0);
        tick();
        drive(d, 1, 0, 0, a, 'hE, '0, 0);
        #1;
        checks++;
        if (g_hit(d) !== 1'b1 || g_way(d) != 1) begin
            errors++;
            $display("FAIL evict_fill d=%0d got hit=%0b way=%0d exp hit=1 way=1", d, g_hit(d), g_way(d));
        end
        tick();
        drive(d, 1, 0, 0, a, 'hB, '0, 0);
        #1;
        checks++;
        if (g_hit(d) !== 1'b0 || obs(d) !== mexp(d, a, 'hB)) begin
            errors++;
            $display("FAIL evicted_miss d=%0d got=%h exp=%h", d, obs(d), mexp(d, a, 'hB));
        end
        tick();
    endtask

    task automatic test_writeback();
        logic [255:0] line = rnd_line();
        logic [285:0] o;
        drive(0, 1, 1, 0, 0, 'h7, line, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 'h8 + i, rnd_line(), 0);
            tick();
        end
        drive(0, 1, 0, 0, 0, 'h20, '0, 0);
        #1;
        o = obs(0);
        checks++;
        if (o !== {1'b0, 2'd0, 25'h7, line, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL writeback got=%h exp=%h", o, {1'b0, 2'd0, 25'h7, line, 1'b1, 1'b1});
        end
        checks++;
        if (o !== mexp(0, 0, 'h20)) begin
            errors++;
            $display("FAIL writeback_model got=%h exp=%h", o, mexp(0, 0, 'h20));
        end
        tick();
    endtask

    task automatic test_invalidate();
        drive(0, 1, 0, 1, 5, 'hC, '0, 0);
        #1;
        checks++;
        if (g_hit(0) !== 1'b1 || g_way(0) != 2) begin
            errors++;
            $display("FAIL inv_hit got hit=%0b way=%0d exp hit=1 way=2", g_hit(0), g_way(0));
        end
        tick();
        drive(0, 1, 0, 0, 5, 'hC, '0, 0);
        #1;
        checks++;
        if (g_hit(0) !== 1'b0 || g_way(0) != 2 || obs(0) !== mexp(0, 5, 'hC)) begin
            errors++;
            $display("FAIL inv_miss got=%h exp=%h", obs(0), mexp(0, 5, 'hC));
        end
        drive(0, 1, 1, 1, 5, 'h33, rnd_line(), 1);
        tick();
        drive(0, 1, 1, 1, 5, 'hD, rnd_line(), 0);
        tick();
        drive(0, 1, 0, 0, 5, 'h33, '0, 0);
        #1;
        checks++;
        if (g_hit(0) !== 1'b1 || g_way(0) != 2 || obs(0) !== mexp(0, 5, 'h33)) begin
            errors++;
            $display("FAIL inv_refill got=%h exp=%h", obs(0), mexp(0, 5, 'h33));
        end
        tick();
        drive(0, 1, 0, 0, 5, 'hD, '0, 0);
        #1;
        checks++;
        if (g_hit(0) !== 1'b1 || g_way(0) != 3 || obs(0) !== mexp(0, 5, 'hD)) begin
            errors++;
            $display("FAIL write_over_inv got=%h exp=%h", obs(0), mexp(0, 5, 'hD));
        end
        tick();
    endtask

    task automatic test_random();
        int a[2], t[2];
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                a[d] = $urandom_range(0, ns[d] - 1);
                t[d] = $urandom_range(0, 5);
                drive(d, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                      a[d], t[d], rnd_line(), $urandom_range(0, 1) == 1);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== mexp(d, a[d], t[d])) begin
                    errors++;
                    $display("FAIL random n=%0d d=%0d got=%h exp=%h", n, d, obs(d), mexp(d, a[d], t[d]));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 1, 0, 2, 'h55, rnd_line(), 1);
        drive(1, 1, 1, 0, 2, 'h55, rnd_line(), 1);
        #2;
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== '0) begin
                errors++;
                $display("FAIL async_reset d=%0d got=%h exp=0", d, obs(d));
            end
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        en[0] = 0; en[1] = 0;
        rst_n = 1;
        for (int s = 0; s < 4; s++)
            for (int d = 0; d < 2; d++) begin
                drive(d, 1, 0, 0, s, (s == 2) ? 'h55 : $urandom_range(0, 5), '0, 0);
                #1;
                checks++;
                if (obs(d) !== '0) begin
                    errors++;
                    $display("FAIL post_reset d=%0d set=%0d got=%h exp=0", d, s, obs(d));
                end
            end
        tick();
    endtask

    initial begin
        rst_n = 0;
        for (int d = 0; d < 2; d++) drive(d, 0, 0, 0, 0, 0, '0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_fill_evict(0);
        test_fill_evict(1);
        test_writeback();
        test_invalidate();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
